music_seq_ctrl: RTL

Sequencer for the 64-entry song ROM (6-bit address `cnt`, registered 5-bit note code `music`, 0 = rest). It steps the ROM address once per beat and absorbs the ROM's one-cycle read latency. It converts each latched note code into a square-wave buzzer output. It provides play/pause/stop/loop control and sits between the user-control debouncers and the buzzer pin.

---
 rtl/music_pkg.sv | 36 +++
 rtl/note_tone_lut.sv | 25 ++
 rtl/music_seq_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/music_pkg.sv
// -----------------------------------------------------------------------------
// music_pkg
// Shared definitions for the song sequencer: sequencer state encoding, note
// and ROM address widths, the seven base pitches (C4..B4) and the function
// that turns a note code into a tone half-period in clock cycles.
// -----------------------------------------------------------------------------
package music_pkg;

  localparam int NOTE_W = 5;   // note code width, 0 = rest
  localparam int ADDR_W = 6;   // song ROM address width (64 entries)
  localparam int HALF_W = 18;  // tone half-period width in clock cycles

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // C4 D4 E4 F4 G4 A4 B4 in Hz
  localparam int unsigned BASE_HZ [7] = '{262, 294, 330, 349, 392, 440, 494};

  // Codes 1-7 are the base octave, 8-14 one octave up, 15-21 two octaves up.
  // Everything else is silent (half-period 0).
  function automatic logic [HALF_W-1:0] half_period(input int unsigned clk_hz,
                                                    input logic [NOTE_W-1:0] code);
    int unsigned idx;
    int unsigned freq;
    if (code == '0 || code > NOTE_W'(21)) return '0;
    idx  = 32'(code) - 32'd1;
    freq = BASE_HZ[idx % 7] << (idx / 7);
    return HALF_W'(clk_hz / (2 * freq));
  endfunction

endpackage

// File: rtl/note_tone_lut.sv
// -----------------------------------------------------------------------------
// note_tone_lut
// Combinational lookup: note code -> tone half-period in clock cycles.
// The table is fully resolved at elaboration, so no divider is built.
//   code  in  5   note code (0 = rest)
//   half  out 18  half-period in cycles, 0 for silent codes
// -----------------------------------------------------------------------------
module note_tone_lut
  import music_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic [NOTE_W-1:0] code,
  output logic [HALF_W-1:0] half
);

  logic [HALF_W-1:0] lut [2**NOTE_W];

  for (genvar g = 0; g < 2**NOTE_W; g++) begin : g_lut
    assign lut[g] = half_period(CLK_HZ, NOTE_W'(g));
  end

  assign half = lut[code];

endmodule

// File: rtl/music_seq_ctrl.sv
// -----------------------------------------------------------------------------
// music_seq_ctrl
// Steps a registered-output song ROM one entry per beat and turns each note
// code into a square wave on the buzzer pin, with play/pause/stop/loop control.
//
// Ports
//   clk      in   system clock
//   rst      in   synchronous reset, active-high
//   play     in   pulse: start, or resume from pause
//   pause    in   pulse: freeze playback (FETCH/PLAY only)
//   stop     in   pulse: abort to idle (highest priority)
//   loop_en  in   level: wrap to entry 0 after the last entry
//   music    in   note code from the ROM, valid one cycle after cnt changes
//   cnt      out  ROM address
//   note     out  note currently sounding, 0 = silence
//   buzzer   out  square-wave tone
//   playing  out  high in FETCH and PLAY
//   done     out  high in DONE
//
// Build option
//   NOTE_GAP_EN  when defined, the last GAP_CYCLES cycles of every beat are
//                silent so repeated notes are heard separately.
//
// Beat timing: FETCH (2 cycles: address to ROM, ROM to note) + PLAY
// (BEAT_CYCLES-2 cycles) = BEAT_CYCLES per entry. The cycle on which pause
// is accepted still advances the counters; every cycle spent in PAUSE,
// including the one that accepts play, is frozen.
// -----------------------------------------------------------------------------
module music_seq_ctrl
  import music_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned BEAT_CYCLES = 12_500_000,
  parameter int unsigned SONG_LEN    = 64,
  parameter int unsigned GAP_CYCLES  = 500_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play,
  input  logic              pause,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [NOTE_W-1:0] music,
  output logic [ADDR_W-1:0] cnt,
  output logic [NOTE_W-1:0] note,
  output logic              buzzer,
  output logic              playing,
  output logic              done
);

  localparam int unsigned PLAY_CYCLES = BEAT_CYCLES - 2;
  localparam int          BEAT_W      = $clog2(PLAY_CYCLES);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PLAY_CYCLES - 1);
  localparam logic [ADDR_W-1:0] CNT_LAST  = ADDR_W'(SONG_LEN - 1);
  // First PLAY-counter value whose following cycle lies in the silent tail;
  // the buzzer is a register, so silencing is decided one cycle early.
  localparam int unsigned GAP_FROM =
    (GAP_CYCLES < PLAY_CYCLES) ? PLAY_CYCLES - 1 - GAP_CYCLES : 0;

`ifdef NOTE_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  state_t            state_q, state_d;
  state_t            resume_q, resume_d;   // FETCH or PLAY to return to
  logic              fcnt_q, fcnt_d;       // FETCH cycle index
  logic [BEAT_W-1:0] bcnt_q, bcnt_d;       // PLAY cycle index
  logic [HALF_W-1:0] tone_q, tone_d;
  logic [ADDR_W-1:0] cnt_d;
  logic [NOTE_W-1:0] note_d;
  logic              buz_d;

  logic [HALF_W-1:0] half;
  logic [HALF_W-1:0] tone_step;
  logic              buz_step;
  logic              in_gap;

  note_tone_lut #(
    .CLK_HZ(CLK_HZ)
  ) u_lut (
    .code(note),
    .half(half)
  );

  assign in_gap = GAP_EN && (GAP_CYCLES != 0) && (state_q == ST_PLAY) &&
                  (bcnt_q >= BEAT_W'(GAP_FROM));

  // One step of the tone oscillator for the note currently held
  always_comb begin
    tone_step = '0;
    buz_step  = 1'b0;
    if (half != '0 && !in_gap) begin
      if (tone_q == half - HALF_W'(1)) begin
        tone_step = '0;
        buz_step  = ~buzzer;
      end else begin
        tone_step = tone_q + HALF_W'(1);
        buz_step  = buzzer;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    fcnt_d   = fcnt_q;
    bcnt_d   = bcnt_q;
    tone_d   = tone_q;
    cnt_d    = cnt;
    note_d   = note;
    buz_d    = buzzer;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (play) begin
          state_d = ST_FETCH;
          cnt_d   = '0;
          fcnt_d  = 1'b0;
          bcnt_d  = '0;
          tone_d  = '0;
          buz_d   = 1'b0;
        end
      end

      ST_FETCH: begin
        // Previous note keeps sounding until the new code is latched
        tone_d = tone_step;
        buz_d  = buz_step;
        if (!fcnt_q) begin
          fcnt_d = 1'b1;
        end else begin
          fcnt_d  = 1'b0;
          note_d  = music;
          tone_d  = '0;
          buz_d   = 1'b0;
          bcnt_d  = '0;
          state_d = ST_PLAY;
        end
      end

      ST_PLAY: begin
        tone_d = tone_step;
        buz_d  = buz_step;
        if (bcnt_q == BEAT_LAST) begin
          bcnt_d = '0;
          if (cnt == CNT_LAST && !loop_en) begin
            state_d = ST_DONE;
            note_d  = '0;
            tone_d  = '0;
            buz_d   = 1'b0;
          end else begin
            state_d = ST_FETCH;
            cnt_d   = (cnt == CNT_LAST) ? '0 : cnt + ADDR_W'(1);
          end
        end else begin
          bcnt_d = bcnt_q + BEAT_W'(1);
        end
      end

      ST_PAUSE: begin
        if (play && !pause) state_d = resume_q;
      end

      default: state_d = ST_IDLE;
    endcase

    // The song finishing wins over a pause arriving on its last cycle
    if (pause && (state_q == ST_FETCH || state_q == ST_PLAY) && state_d != ST_DONE) begin
      resume_d = state_d;
      state_d  = ST_PAUSE;
      buz_d    = 1'b0;
    end

    if (stop) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      note_d  = '0;
      buz_d   = 1'b0;
      tone_d  = '0;
      fcnt_d  = 1'b0;
      bcnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      resume_q <= ST_IDLE;
      fcnt_q   <= 1'b0;
      bcnt_q   <= '0;
      tone_q   <= '0;
      cnt      <= '0;
      note     <= '0;
      buzzer   <= 1'b0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      fcnt_q   <= fcnt_d;
      bcnt_q   <= bcnt_d;
      tone_q   <= tone_d;
      cnt      <= cnt_d;
      note     <= note_d;
      buzzer   <= buz_d;
    end
  end

  assign playing = (state_q == ST_FETCH) || (state_q == ST_PLAY);
  assign done    = (state_q == ST_DONE);

endmodule
